// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the two-entry pipeline stage buffer: default bus
// widths and the occupancy state encoding.
package pipe_stage_buf_pkg;

  localparam int DATA_BUS_WIDTH     = 32;
  localparam int REG_ADDR_BUS_WIDTH = 5;

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage : pipe_stage_buf_pkg

// File: rtl/pipe_payload_reg.sv
// Enabled payload register with asynchronous clear; used for both the main
// (output-facing) entry and the skid entry of the stage buffer.
module pipe_payload_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Load new payload only when enabled; otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : pipe_payload_reg

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages. The main entry drives the
// outputs; the skid entry absorbs one extra item so in_ready can be a flop
// with no combinational path from out_ready.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_BUS_WIDTH,
  parameter int REG_ADDR_WIDTH = REG_ADDR_BUS_WIDTH,
  parameter int SIDE_WIDTH     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     result_in,
  input  logic                      write_reg_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
  input  logic [SIDE_WIDTH-1:0]     side_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      write_reg_en_out,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out,
  output logic [SIDE_WIDTH-1:0]     side_out,
  output logic [1:0]                occupancy
);

  // Payload is carried as one flat vector: {side, addr, en, result}.
  localparam int PAY_W = SIDE_WIDTH + REG_ADDR_WIDTH + 1 + DATA_WIDTH;

  buf_state_e       state_d;
  buf_state_e       state_q;
  logic             in_ready_d;
  logic             in_ready_q;

  logic             in_fire;
  logic             out_fire;

  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;

  assign in_pay   = {side_in, write_reg_addr_in, write_reg_en_in, result_in};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != ST_EMPTY) & out_ready;

  // Next-state and payload-load decisions; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    // Ready is registered: it reflects whether the next state has room.
    in_ready_d = (state_d != ST_TWO);
  end

  // Main entry refills from skid when draining TWO, otherwise from input.
  always_comb begin
    main_d = in_pay;
    if (main_from_skid) begin
      main_d = skid_q;
    end
  end

  // Control state and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_payload_reg #(
    .WIDTH (PAY_W)
  ) u_main_reg (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_reg #(
    .WIDTH (PAY_W)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_pay),
    .q   (skid_q)
  );

  assign in_ready           = in_ready_q;
  assign out_valid          = (state_q != ST_EMPTY);
  assign occupancy          = state_q;
  assign result_out         = main_q[DATA_WIDTH-1:0];
  assign write_reg_en_out   = main_q[DATA_WIDTH] & out_valid;
  assign write_reg_addr_out = main_q[DATA_WIDTH+1 +: REG_ADDR_WIDTH];
  assign side_out           = main_q[DATA_WIDTH+1+REG_ADDR_WIDTH +: SIDE_WIDTH];

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a long
// randomized run against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 1;

  typedef struct {
    logic [DW-1:0] res;
    logic          en;
    logic [AW-1:0] addr;
    logic [SW-1:0] side;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] result_in;
  logic          write_reg_en_in;
  logic [AW-1:0] write_reg_addr_in;
  logic [SW-1:0] side_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result_out;
  logic          write_reg_en_out;
  logic [AW-1:0] write_reg_addr_out;
  logic [SW-1:0] side_out;
  logic [1:0]    occupancy;

  int checks;
  int errors;

  // Reference model: an ordered queue of accepted entries, capacity two.
  entry_t model_q[$];

  pipe_stage_buf #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .SIDE_WIDTH     (SW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .result_in          (result_in),
    .write_reg_en_in    (write_reg_en_in),
    .write_reg_addr_in  (write_reg_addr_in),
    .side_in            (side_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .result_out         (result_out),
    .write_reg_en_out   (write_reg_en_out),
    .write_reg_addr_out (write_reg_addr_out),
    .side_out           (side_out),
    .occupancy          (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, applying the queue rules to the model, then
  // settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    bit     acc;
    bit     pop;
    entry_t e;
    @(posedge clk);
    acc = in_valid && (model_q.size() < 2);
    pop = out_ready && (model_q.size() > 0);
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) begin
        e.res  = result_in;
        e.en   = write_reg_en_in;
        e.addr = write_reg_addr_in;
        e.side = side_in;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] r, input logic en,
                       input logic [AW-1:0] a, input logic [SW-1:0] s);
    in_valid          = v;
    result_in         = r;
    write_reg_en_in   = en;
    write_reg_addr_in = a;
    side_in           = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        write_reg_en_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b occ=%0d ready=%b wen=%b, want 0 0 1 0",
               out_valid, occupancy, in_ready, write_reg_en_out);
    end
    checks++;
    if (result_out !== '0 || write_reg_addr_out !== '0 || side_out !== '0) begin
      errors++;
      $display("FAIL reset_payload: res=%h addr=%h side=%h, want zeros",
               result_out, write_reg_addr_out, side_out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b1, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || occupancy !== 2'd1 || result_out !== 32'h1234_5678 ||
        write_reg_addr_out !== 5'd5 || write_reg_en_out !== 1'b1 || side_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: v=%b occ=%0d res=%h addr=%0d wen=%b side=%b, want 1 1 12345678 5 1 1",
               out_valid, occupancy, result_out, write_reg_addr_out, write_reg_en_out, side_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || write_reg_en_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: v=%b occ=%0d wen=%b, want 0 0 0",
               out_valid, occupancy, write_reg_en_out);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b1, 5'd1, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 5'd2, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || result_out !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: occ=%0d ready=%b res=%h, want 2 0 a",
               occupancy, in_ready, result_out);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || result_out !== 32'hB ||
        write_reg_en_out !== 1'b0 || write_reg_addr_out !== 5'd2) begin
      errors++;
      $display("FAIL bp_pop1: occ=%0d ready=%b res=%h wen=%b addr=%0d, want 1 1 b 0 2",
               occupancy, in_ready, result_out, write_reg_en_out, write_reg_addr_out);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop2: occ=%0d v=%b, want 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + i, i[0], i[4:0], i[1]);
      tick();
      if (out_valid !== 1'b1 || result_out !== (32'h100 + i) || occupancy !== 2'd1 ||
          in_ready !== 1'b1) begin
        bad++;
        if (bad < 5)
          $display("FAIL b2b_cycle%0d: v=%b res=%h occ=%0d rdy=%b, want 1 %h 1 1",
                   i, out_valid, result_out, occupancy, in_ready, 32'h100 + i);
      end
    end
    checks++;
    if (bad != 0) errors++;
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'hF1, 1'b1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 32'hF2, 1'b1, 5'd4, 1'b0);
    tick();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: occ=%0d, want 2", occupancy);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hF3, 1'b1, 5'd6, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || write_reg_en_out !== 1'b0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: occ=%0d v=%b wen=%b rdy=%b, want 0 0 0 1",
               occupancy, out_valid, write_reg_en_out, in_ready);
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_noreturn: v=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hC1, 1'b1, 5'd7, 1'b1);
    tick();
    drive(1'b1, 32'hC2, 1'b1, 5'd8, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
        write_reg_en_out !== 1'b0 || result_out !== '0 || write_reg_addr_out !== '0 ||
        side_out !== '0) begin
      errors++;
      $display("FAIL async_rst: v=%b occ=%0d rdy=%b wen=%b res=%h addr=%h side=%h, want 0 0 1 0 0 0 0",
               out_valid, occupancy, in_ready, write_reg_en_out, result_out,
               write_reg_addr_out, side_out);
    end
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    out_ready = 1'b1;
    drive(1'b1, 32'h5, 1'b1, 5'd9, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || result_out !== 32'h5 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL async_rst_push: v=%b res=%h occ=%0d, want 1 5 1",
               out_valid, result_out, occupancy);
    end
    tick();
  endtask

  task automatic test_random();
    int     bad;
    entry_t h;
    bit     exp_v;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 1));
      tick();
      exp_v = (model_q.size() > 0);
      if (occupancy > 2'd2 || occupancy !== model_q.size() || out_valid !== exp_v ||
          in_ready !== (model_q.size() < 2)) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_ctrl_c%0d: occ=%0d v=%b rdy=%b, want occ=%0d", c,
                   occupancy, out_valid, in_ready, model_q.size());
      end else if (exp_v) begin
        h = model_q[0];
        if (result_out !== h.res || write_reg_en_out !== h.en ||
            write_reg_addr_out !== h.addr || side_out !== h.side) begin
          bad++;
          if (bad < 5)
            $display("FAIL rand_data_c%0d: res=%h en=%b addr=%0d side=%b, want %h %b %0d %b",
                     c, result_out, write_reg_en_out, write_reg_addr_out, side_out,
                     h.res, h.en, h.addr, h.side);
        end
      end else if (write_reg_en_out !== 1'b0) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_wen_c%0d: wen=%b, want 0", c, write_reg_en_out);
      end
    end
    checks++;
    if (bad != 0) errors++;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_buf

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of result payload.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, width of write-back register address.
REQ-003 SHALL have parameter SIDE_WIDTH, default 1, width of opaque sideband payload (passed unchanged).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept; registered.
- result_in  in  DATA_WIDTH  result payload.
- write_reg_en_in  in  1  write-back enable.
- write_reg_addr_in  in  REG_ADDR_WIDTH  write-back address.
- side_in  in  SIDE_WIDTH  sideband payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- result_out  out  DATA_WIDTH  head result.
- write_reg_en_out  out  1  head write enable, gated by out_valid.
- write_reg_addr_out  out  REG_ADDR_WIDTH  head address.
- side_out  out  SIDE_WIDTH  head sideband.
- occupancy  out  2  entries held, 0..2.

Function
REQ-006 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, sampled at rising clk.
REQ-007 SHALL hold at most two entries: main register (drives outputs) and skid register.
REQ-008 SHALL implement states EMPTY, ONE, TWO; occupancy = 0/1/2 respectively; out_valid = (state != EMPTY).
REQ-009 EMPTY: in_fire -> ONE, main <= input; else stay.
REQ-010 ONE: in_fire & out_fire -> ONE, main <= input; in_fire only -> TWO, skid <= input; out_fire only -> EMPTY; neither -> stay.
REQ-011 TWO: out_fire -> ONE, main <= skid; else stay; in_ready = 0 throughout.
REQ-012 in_ready SHALL be a flop, equal to 1 in EMPTY and ONE and 0 in TWO, with no combinational path from out_ready.
REQ-013 Latency SHALL be one cycle: entry accepted at edge N appears on outputs after edge N when block was EMPTY.
REQ-014 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-015 write_reg_en_out SHALL equal stored enable AND out_valid; 0 whenever out_valid = 0.
REQ-016 result_out, write_reg_addr_out, side_out SHALL hold last main value when invalid (content don't-care to consumers).
REQ-017 flush SHALL move state to EMPTY at next edge, dropping held entries and any same-cycle input; flush dominates in_fire and out_fire.
REQ-018 In the cycle flush is asserted, an out_fire SHALL still count as consumed by downstream (block output is unaffected combinationally).
REQ-019 After flush, in_ready SHALL be 1 from the following cycle.
REQ-020 Payload SHALL not be altered; widths pass through without extension or truncation.

Reset
REQ-021 rst SHALL asynchronously force state EMPTY, in_ready 1, out_valid 0, occupancy 0, write_reg_en_out 0, all payload registers 0.
REQ-022 rst asserted mid-operation SHALL discard all entries immediately; first acceptance possible at first rising edge after rst deasserts.

Structure
REQ-023 State encoding constants and default widths (DATA_BUS_WIDTH, REG_ADDR_BUS_WIDTH) SHALL live in the shared global definitions package.
REQ-024 One sub-module, pipe_payload_reg (enabled, async-reset payload register, width parameter), SHALL be instantiated for main and skid registers.

Verification
REQ-025 Reset then in_valid with result 0x1234_5678, addr 5, en 1, out_ready 1 -> outputs show it after one edge, out_valid 1, occupancy 1.
REQ-026 out_ready 0, push 0xA then 0xB -> occupancy 2, in_ready 0; raise out_ready -> 0xA then 0xB in order, in_ready 1 after first pop.
REQ-027 Continuous in_valid and out_ready for 100 cycles with incrementing data -> one entry per cycle, no gaps, no drops, order preserved.
REQ-028 State TWO, assert flush with in_valid 1 -> next cycle occupancy 0, out_valid 0, write_reg_en_out 0, in_ready 1; flushed entries never reappear.
REQ-029 Assert rst asynchronously between edges while occupancy 2 -> outputs zero without clock edge; after release push 0x5 -> seen after one edge.
REQ-030 Random in_valid/out_ready/flush for 10 000 cycles against scoreboard model -> zero mismatches, occupancy never exceeds 2.
